// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and control encodings for multicycle_ctrl
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_ALUI, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_HALT
    } iclass_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BRZ   = 4'b0100;
    localparam logic [3:0] OP_JUMP  = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] IMM27 = 2'b00;
    localparam logic [1:0] IMM17 = 2'b01;
    localparam logic [1:0] IMM16 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode: immediate format, class, illegal flag
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [1:0] o_imm_src,
    output iclass_t    o_iclass,
    output logic       o_illegal
);

    always_comb begin
        o_imm_src = IMM27;
        o_iclass  = C_RTYPE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: o_iclass = C_RTYPE;
            OP_ALUI:  begin o_iclass = C_ALUI;   o_imm_src = IMM17; end
            OP_LOAD:  begin o_iclass = C_LOAD;   o_imm_src = IMM17; end
            OP_STORE: begin o_iclass = C_STORE;  o_imm_src = IMM17; end
            OP_BRZ:   begin o_iclass = C_BRANCH; o_imm_src = IMM16; end
            OP_JUMP:  o_iclass = C_JUMP;
            OP_HALT:  o_iclass = C_HALT;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath sequencer; MEM_TIMEOUT_EN adds a memory wait timeout
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  imm_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        fault
);

    state_t     r_state;
    state_t     w_next;
    iclass_t    r_iclass;
    logic [1:0] r_imm_src;
    logic [1:0] w_dec_imm;
    iclass_t    w_dec_class;
    logic       w_dec_illegal;
    logic       w_limit;
    logic       w_expire;
    logic       w_unused;

    ctrl_decode u_decode (
        .i_opcode  (instr[31:28]),
        .o_imm_src (w_dec_imm),
        .o_iclass  (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
            r_wait_cnt <= '0;
        end else if (mem_req && !mem_ready && (r_wait_cnt != CW'(MEM_TIMEOUT))) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    assign w_limit  = ((r_state == S_FETCH) || (r_state == S_MEM)) && (r_wait_cnt == CW'(MEM_TIMEOUT));
    assign w_unused = ^instr[27:0];
`else
    assign w_limit  = 1'b0;
    assign w_unused = ^{instr[27:0], (MEM_TIMEOUT > 0)};
`endif

    // At the limit a late mem_ready still completes; otherwise the request is withdrawn.
    assign w_expire = w_limit && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_imm_src <= IMM27;
            r_iclass  <= C_RTYPE;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_imm_src <= w_dec_imm;
                r_iclass  <= w_dec_class;
            end
        end
    end

    assign imm_src = r_imm_src;

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = !w_expire;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_expire) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (w_dec_illegal)              w_next = S_FAULT;
                else if (w_dec_class == C_HALT) w_next = S_HALT;
                else                            w_next = S_EXEC;
            end
            S_EXEC: begin
                case (r_iclass)
                    C_RTYPE: begin alu_op = ALU_FUNCT; w_next = S_WB; end
                    C_ALUI:  begin alu_src = 1'b1; w_next = S_WB; end
                    C_LOAD, C_STORE: begin alu_src = 1'b1; w_next = S_MEM; end
                    C_BRANCH: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                        w_next   = S_FETCH;
                    end
                    C_JUMP: begin pc_src = PC_JUMP; pc_write = 1'b1; w_next = S_FETCH; end
                    default: w_next = S_FAULT;
                endcase
            end
            S_MEM: begin
                mem_req = !w_expire;
                adr_src = 1'b1;
                mem_we  = (r_iclass == C_STORE) && !w_expire;
                if (mem_ready)     w_next = (r_iclass == C_STORE) ? S_FETCH : S_WB;
                else if (w_expire) w_next = S_FAULT;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_iclass == C_LOAD);
                w_next     = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - phase-level reference model bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write;
    logic [1:0]  pc_src, imm_src, alu_op;
    logic        alu_src, reg_write, mem_to_reg, halted, fault;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .imm_src(imm_src), .alu_src(alu_src),
        .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] imm_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       halted;
        logic       fault;
    } outs_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] m_imm = 2'b00;
    bit         m_term = 1'b0;

    function automatic outs_t observed();
        return {mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, imm_src,
                alu_src, alu_op, reg_write, mem_to_reg, halted, fault};
    endfunction

    task automatic chk(input string tag, input outs_t exp);
        outs_t o;
        o = observed();
        n_checks++;
        assert (o === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    // One controller cycle: drive inputs just after the edge, compare mid-cycle.
    task automatic step(input logic rdy, input logic z, input outs_t exp, input string tag);
        mem_ready = rdy;
        zero      = z;
        #2;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic terminal(input bit is_halt);
        outs_t e;
        m_term    = 1'b1;
        e         = '0;
        e.imm_src = m_imm;
        e.halted  = is_halt;
        e.fault   = !is_halt;
        repeat (3) step(1'($urandom), 1'($urandom), e, is_halt ? "halt_hold" : "fault_hold");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_async", '0);
        @(posedge clk);
        #1;
        chk("reset_hold", '0);
        rst_n  = 1'b1;
        m_imm  = 2'b00;
        m_term = 1'b0;
        step(1'b1, 1'($urandom), '0, "idle");
    endtask

    // A memory phase: `waits` cycles of mem_ready low, then one with it high.
    task automatic mem_phase(input bit is_mem, input logic we, input int waits, output bit died);
        outs_t e;
        died = 1'b0;
        for (int i = 0; i < waits; i++) begin
`ifdef MEM_TIMEOUT_EN
            if (i == TO) begin
                e         = '0;
                e.adr_src = is_mem;
                e.imm_src = m_imm;
                step(1'b0, 1'($urandom), e, is_mem ? "mem_expire" : "fetch_expire");
                terminal(1'b0);
                died = 1'b1;
                return;
            end
`endif
            e         = '0;
            e.mem_req = 1'b1;
            e.adr_src = is_mem;
            e.mem_we  = we;
            e.imm_src = m_imm;
            step(1'b0, 1'($urandom), e, is_mem ? "mem_wait" : "fetch_wait");
        end
        e          = '0;
        e.mem_req  = 1'b1;
        e.adr_src  = is_mem;
        e.mem_we   = we;
        e.imm_src  = m_imm;
        e.ir_write = !is_mem;
        e.pc_write = !is_mem;
        step(1'b1, 1'($urandom), e, is_mem ? "mem_done" : "fetch_done");
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic zv, input int fw, input int mw);
        logic [3:0] op;
        outs_t      e;
        bit         died;
        op     = ins[31:28];
        instr  = ins;
        m_term = 1'b0;
        mem_phase(1'b0, 1'b0, fw, died);
        if (died) return;
        e         = '0;
        e.imm_src = m_imm;
        step(1'($urandom), 1'($urandom), e, "decode");
        case (op)
            4'h1, 4'h2, 4'h3: m_imm = 2'b01;
            4'h4:             m_imm = 2'b10;
            default:          m_imm = 2'b00;
        endcase
        if (op == 4'hF) begin terminal(1'b1); return; end
        if (op > 4'h5)  begin terminal(1'b0); return; end
        e         = '0;
        e.imm_src = m_imm;
        case (op)
            4'h0:             e.alu_op = 2'b10;
            4'h1, 4'h2, 4'h3: e.alu_src = 1'b1;
            4'h4: begin e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = zv; end
            default: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
        endcase
        step(1'($urandom), (op == 4'h4) ? zv : 1'($urandom), e, "exec");
        if (op == 4'h2 || op == 4'h3) begin
            mem_phase(1'b1, op == 4'h3, mw, died);
            if (died) return;
        end
        if (op <= 4'h2) begin
            e            = '0;
            e.imm_src    = m_imm;
            e.reg_write  = 1'b1;
            e.mem_to_reg = (op == 4'h2);
            step(1'($urandom), 1'($urandom), e, "wb");
        end
    endtask

    initial begin
        outs_t e;
        int    r;
        logic [3:0] op;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", '0);
        do_reset();

        run_instr(32'h2000_0010, 1'b0, 0, 0);
        run_instr(32'h4000_0008, 1'b1, 0, 0);
        run_instr(32'h4000_0008, 1'b0, 0, 0);
        run_instr(32'h3000_0004, 1'b0, 0, 3);
        run_instr(32'h0400_0000, 1'b0, 2, 0);
        run_instr(32'h5000_0100, 1'b0, 1, 0);
        run_instr(32'h1000_0001, 1'b0, 0, 0);
        run_instr(32'h7000_0000, 1'b0, 0, 0);
        do_reset();
        run_instr(32'hF000_0000, 1'b0, 0, 0);
        do_reset();

        mem_ready = 1'b0;
        #2;
        e         = '0;
        e.mem_req = 1'b1;
        chk("fetch_before_reset", e);
        do_reset();

        run_instr(32'h0000_0000, 1'b0, 10, 0);
        if (m_term) do_reset();
`ifdef MEM_TIMEOUT_EN
        run_instr(32'h0000_0000, 1'b0, TO, 0);
        run_instr(32'h3000_0000, 1'b0, 0, TO + 2);
        do_reset();
`endif

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 15);
            op = (r < 12) ? 4'(r % 6) : ((r < 14) ? 4'hF : 4'h9);
            run_instr({op, 28'($urandom)}, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
            if (m_term) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle build of the processor datapath. It issues per-state control strobes for instruction fetch, decode, execute, memory access and writeback. It selects the immediate format driven into the sign-extend unit (imm_src) and manages the memory request/ready handshake. It sits beside the datapath, takes the latched instruction and the ALU zero flag, and drives every datapath enable and mux select.

## Interface
- MEM_TIMEOUT, 16: cycles a memory request may wait for mem_ready before faulting (used only with the timeout feature).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register contents; opcode = instr[31:28], ALU function = instr[27:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  store when 1.
- adr_src  out  1  address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- imm_src  out  2  sign-extend format: 00 = imm27, 01 = imm17, 10 = imm16.
- alu_src  out  1  ALU B operand: 0 = register, 1 = immediate.
- alu_op  out  2  00 = add, 01 = subtract, 1x = instr[27:26] passthrough (R-type).
- reg_write  out  1  register file write.
- mem_to_reg  out  1  writeback source: 1 = memory data.
- halted  out  1  in HALT state.
- fault  out  1  in FAULT state.

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 ALU-imm (imm17)
  - 0010 load (imm17)
  - 0011 store (imm17)
  - 0100 branch-if-zero (imm16)
  - 0101 jump (imm27)
  - 1111 halt
  - all others illegal
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- IDLE: the reset state. All strobes are 0. Goes to FETCH next cycle.
- FETCH: mem_req=1, adr_src=0. When mem_ready=1, the controller pulses ir_write=1 and pc_write=1 with pc_src=00 in the same cycle, then goes to DECODE. Otherwise it stays in FETCH.
- DECODE: imm_src is registered from the opcode. Illegal opcode goes to FAULT, 1111 goes to HALT, everything else goes to EXEC.
- EXEC:
  - R-type: alu_src=0, alu_op=1x, then WB.
  - ALU-imm/load/store: alu_src=1, alu_op=00. ALU-imm goes to WB; load and store go to MEM.
  - Branch: alu_src=0, alu_op=01, pc_src=01, pc_write=zero, then FETCH.
  - Jump: pc_src=10, pc_write=1, then FETCH.
- MEM: mem_req=1, adr_src=1, mem_we=1 for store. Waits for mem_ready. Store then goes to FETCH; load goes to WB.
- WB: reg_write=1, mem_to_reg=1 for load, then FETCH.
- HALT and FAULT are terminal; only rst_n leaves them. All strobes are 0 there.
- Strobe outputs are a function of state, plus mem_ready/zero where stated. imm_src holds its value until the next DECODE.

## Timing
- Reset values: all outputs 0, imm_src=00, state IDLE.
- Asynchronous assertion of rst_n mid-operation forces IDLE immediately. An outstanding mem_req drops in the same cycle.
- Cycles per instruction with zero-wait memory:
  - branch/jump: 3
  - R-type, ALU-imm, store: 4
  - load: 5
- Each cycle mem_ready is low in FETCH or MEM adds one cycle.
- mem_ready is ignored outside FETCH and MEM.
- mem_req stays high continuously until the cycle mem_ready is sampled high.
- imm_src becomes valid on the first EXEC cycle and stays stable through WB.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH or MEM and counts each cycle with mem_req=1 and mem_ready=0.
  - When the count reaches MEM_TIMEOUT, the next state is FAULT and mem_req drops.
  - mem_ready arriving in the same cycle the limit is reached wins: the transfer completes normally.
- MEM_TIMEOUT_EN undefined:
  - No counter exists; the controller waits indefinitely.
  - fault is raised only by an illegal opcode.

## Structure
- Shared package ctrl_pkg holds:
  - the state enum
  - 4-bit opcode constants
  - imm_src encodings (IMM27, IMM17, IMM16)
  - pc_src encodings
  - alu_op encodings
- Sub-module ctrl_decode is combinational: opcode in; imm_src, instruction class and illegal flag out. It is instantiated once in DECODE-path logic.

## Test plan
- Reset, then release with mem_ready=1: IDLE for 1 cycle, then mem_req=1, ir_write=1, pc_write=1 on the first FETCH cycle.
- Load (instr=0x2000_0010), mem_ready=1 always: imm_src=01 from EXEC. In MEM, mem_req=1 with adr_src=1 and mem_we=0. WB has reg_write=1 and mem_to_reg=1. Total 5 cycles.
- Branch (0x4000_0008):
  - zero=1: pc_write=1 and pc_src=01 in EXEC, imm_src=10.
  - zero=0: pc_write=0.
  - Next state FETCH in both cases.
- Store with mem_ready held low 3 cycles in MEM: mem_req and mem_we stay high for 4 cycles, with no reg_write.
- Opcode 0111 reaches FAULT after DECODE; opcode 1111 reaches HALT. In both, outputs stay 0 until rst_n.
- With MEM_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ready held low in FETCH: fault=1 after 4 wait cycles and mem_req=0. Repeat with mem_ready rising exactly at the limit: the fetch completes and the controller goes to DECODE.
